// File: rtl/timer_pkg.sv
// Shared definitions for the BCD shot-clock timer: FSM encoding and BCD digit constants.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-decimal nibbles (A..F) are clamped to the largest legal digit.
    function automatic logic [BCD_W-1:0] sanitise_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_dec_digit.sv
// Combinational single-digit BCD decrement with borrow; sanitises its input digit first.
module bcd_dec_digit
    import timer_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit_out,
    output logic             borrow_out
);

    logic [BCD_W-1:0] w_digit;

    always_comb begin
        w_digit    = sanitise_digit(digit);
        digit_out  = w_digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (w_digit == '0) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out  = w_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/shot_clock_timer.sv
// BCD countdown timer: prescaled tick, start/pause/reload control and a one-cycle expiry pulse.
// Every output is a register or a direct decode of registers.
module shot_clock_timer
    import timer_pkg::*;
#(
    parameter int                    CLK_HZ    = 100_000_000,
    parameter int                    TICK_HZ   = 10,
    parameter int                    DIGITS    = 3,
    parameter logic [4*DIGITS-1:0]   RESET_BCD = 12'h240
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  reload,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  running,
    output logic                  zero,
    output logic                  expired,
    output logic [1:0]            dbg_state
);

    localparam int CW  = BCD_W * DIGITS;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    function automatic logic [CW-1:0] sanitise_bcd(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*BCD_W +: BCD_W] = sanitise_digit(v[i*BCD_W +: BCD_W]);
        end
        return r;
    endfunction

    localparam logic [CW-1:0] COUNT_INIT = sanitise_bcd(RESET_BCD);

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_presc, w_presc_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic            r_expired, w_expired_nxt;

    logic            w_tick;
    logic [CW-1:0]   w_dec;
    logic [DIGITS:0] w_borrow;

    assign w_tick      = (r_state == ST_RUN) && (r_presc == PRESC_MAX);
    assign w_borrow[0] = w_tick;

    // Borrow ripples from digit 0 upward; the tick is the borrow into the least significant digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_dec_digit u_digit (
            .digit      (r_count[g*BCD_W +: BCD_W]),
            .borrow_in  (w_borrow[g]),
            .digit_out  (w_dec[g*BCD_W +: BCD_W]),
            .borrow_out (w_borrow[g+1])
        );
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_count_nxt   = r_count;
        w_expired_nxt = 1'b0;

        if (reload) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
            w_count_nxt = sanitise_bcd(load_bcd);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_presc_nxt = '0;
                        w_state_nxt = (r_count == '0) ? ST_EXPIRED : ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_presc_nxt = w_tick ? '0 : (r_presc + PW'(1));
                    if (pause) begin
                        w_state_nxt = ST_PAUSED;
                    end
                    // A borrow out of the top digit would mean underflow; the count holds instead.
                    if (w_tick && !w_borrow[DIGITS]) begin
                        w_count_nxt = w_dec;
                        if (w_dec == '0) begin
                            w_expired_nxt = 1'b1;
                            w_state_nxt   = ST_EXPIRED;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause && start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_count   <= COUNT_INIT;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_count   <= w_count_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    assign count_bcd = r_count;
    assign running   = (r_state == ST_RUN);
    assign zero      = (r_count == '0);
    assign expired   = r_expired;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_shot_clock_timer.sv
// Directed bench for shot_clock_timer with DIV=10, DIGITS=3, reset value 24.0.
module tb_shot_clock_timer;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pause;
  logic        reload;
  logic [11:0] load_bcd;
  logic [11:0] count_bcd;
  logic        running;
  logic        zero;
  logic        expired;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_pulses = 0;

  shot_clock_timer #(
    .CLK_HZ   (100),
    .TICK_HZ  (10),
    .DIGITS   (3),
    .RESET_BCD(12'h240)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pause    (pause),
    .reload   (reload),
    .load_bcd (load_bcd),
    .count_bcd(count_bcd),
    .running  (running),
    .zero     (zero),
    .expired  (expired),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (expired) exp_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: each returns 1 ns after the edge that sampled the stimulus
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
  endtask

  task automatic do_reload(input logic [11:0] v);
    load_bcd = v;
    reload   = 1'b1;
    cyc(1);
    reload   = 1'b0;
  endtask

  int p0;

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; reload = 1'b0; load_bcd = '0;
    cyc(3);
    check("rst_count", count_bcd, 12'h240);
    check("rst_running", running, 0);
    check("rst_expired", expired, 0);
    check("rst_zero", zero, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    cyc(2);

    // full countdown from 24.0
    do_start();
    check("run_running", running, 1);
    cyc(9);
    check("run_before_tick", count_bcd, 12'h240);
    cyc(1);
    check("run_first_tick", count_bcd, 12'h239);
    cyc(2389);
    check("run_at_001", count_bcd, 12'h001);
    check("run_no_pulse_yet", exp_pulses, 0);
    cyc(1);
    check("exp_count", count_bcd, 12'h000);
    check("exp_pulse", expired, 1);
    check("exp_zero", zero, 1);
    check("exp_state", dbg_state, S_EXPIRED);
    check("exp_running", running, 0);
    cyc(1);
    check("exp_pulse_drop", expired, 0);
    do_start();
    cyc(20);
    check("exp_start_ignored", dbg_state, S_EXPIRED);
    check("exp_count_held", count_bcd, 12'h000);
    check("exp_single_pulse", exp_pulses, 1);

    // borrow chain
    do_reload(12'h100);
    check("reload_state", dbg_state, S_IDLE);
    check("reload_count", count_bcd, 12'h100);
    do_start();
    cyc(10);
    check("borrow_100", count_bcd, 12'h099);
    do_reload(12'h010);
    do_start();
    cyc(10);
    check("borrow_010", count_bcd, 12'h009);

    // pause with prescaler held at 6
    do_reload(12'h050);
    do_start();
    cyc(5);
    do_pause();
    check("pause_state", dbg_state, S_PAUSED);
    check("pause_running", running, 0);
    cyc(50);
    check("pause_held", count_bcd, 12'h050);
    do_start();
    check("resume_running", running, 1);
    cyc(3);
    check("resume_not_yet", count_bcd, 12'h050);
    cyc(1);
    check("resume_tick", count_bcd, 12'h049);
    start = 1'b1; pause = 1'b1;
    cyc(1);
    check("start_pause_run", dbg_state, S_PAUSED);
    cyc(1);
    start = 1'b0; pause = 1'b0;
    check("start_pause_paused", dbg_state, S_PAUSED);

    // reload coinciding with a tick, with sanitisation of digit A
    do_reload(12'h050);
    do_start();
    cyc(9);
    p0 = exp_pulses;
    do_reload(12'h2A5);
    check("reload_tick_count", count_bcd, 12'h295);
    check("reload_tick_state", dbg_state, S_IDLE);
    check("reload_tick_expired", expired, 0);
    cyc(15);
    check("reload_idle_hold", count_bcd, 12'h295);
    check("reload_no_pulse", exp_pulses, p0);

    // zero load
    do_reload(12'h000);
    check("zero_load_zero", zero, 1);
    do_start();
    check("zero_start_state", dbg_state, S_EXPIRED);
    check("zero_start_expired", expired, 0);
    cyc(5);
    check("zero_no_pulse", exp_pulses, p0);
    do_reload(12'h001);
    check("one_zero", zero, 0);
    do_start();
    cyc(9);
    check("one_before", count_bcd, 12'h001);
    cyc(1);
    check("one_expired", expired, 1);
    check("one_count", count_bcd, 12'h000);
    cyc(5);
    check("one_single_pulse", exp_pulses, p0 + 1);

    // asynchronous reset mid-run
    do_reload(12'h300);
    do_start();
    cyc(13);
    check("mid_before_rst", count_bcd, 12'h299);
    #2 rst_n = 1'b0;
    #1;
    check("async_count", count_bcd, 12'h240);
    check("async_running", running, 0);
    check("async_state", dbg_state, S_IDLE);
    check("async_zero", zero, 0);
    check("async_expired", expired, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    check("post_rst_idle", count_bcd, 12'h240);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
